// File: rtl/pe_edge_seq.sv
// Array-edge sequencer for one border PE: pulls K operand pairs, drives the PE
// serial control set and returns the accumulated sum on a valid/ready port.
module pe_edge_seq #(
  parameter int unsigned IWIDTH = 16,
  parameter int unsigned IDEPTH = 4,
  parameter int unsigned OWIDTH = 32,
  parameter int unsigned KWIDTH = 8,
  parameter int unsigned LAT    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KWIDTH-1:0] k_len,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_ifm,
  input  logic [IWIDTH-1:0] in_wght,
  output logic [IDEPTH-1:0] idx,
  output logic              mac_done,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic [IWIDTH-1:0] ifm,
  output logic [IWIDTH-1:0] wght,
  output logic [OWIDTH-1:0] ofm,
  input  logic [OWIDTH-1:0] ofm_d,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OWIDTH-1:0] res_data
);

  localparam int unsigned       DCW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [IDEPTH-1:0] IDX_LAST  = '1;
  localparam logic [DCW-1:0]    DCNT_LAST = DCW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t            state_q, state_n;
  logic [KWIDTH-1:0] rem_q, rem_n;
  logic [DCW-1:0]    dcnt_q, dcnt_n;
  logic [IDEPTH-1:0] idx_n;

  // Transition events shared between next-state and output logic
  logic take, cap, fin, zero_job;

  logic              busy_n, done_n, in_ready_n, mac_done_n;
  logic              en_i_n, en_w_n, en_o_n, clr_n, res_valid_n;
  logic [IWIDTH-1:0] ifm_n, wght_n;
  logic [OWIDTH-1:0] res_data_n;

  // Border PE has no upstream partial sum
  assign ofm = '0;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      dcnt_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_ready  <= 1'b0;
      idx       <= '0;
      mac_done  <= 1'b0;
      en_i      <= 1'b0;
      en_w      <= 1'b0;
      en_o      <= 1'b0;
      clr_i     <= 1'b0;
      clr_w     <= 1'b0;
      clr_o     <= 1'b0;
      ifm       <= '0;
      wght      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state_q   <= state_n;
      rem_q     <= rem_n;
      dcnt_q    <= dcnt_n;
      busy      <= busy_n;
      done      <= done_n;
      in_ready  <= in_ready_n;
      idx       <= idx_n;
      mac_done  <= mac_done_n;
      en_i      <= en_i_n;
      en_w      <= en_w_n;
      en_o      <= en_o_n;
      clr_i     <= clr_n;
      clr_w     <= clr_n;
      clr_o     <= clr_n;
      ifm       <= ifm_n;
      wght      <= wght_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
    end
  end

  // Next state, counters and transition events
  always_comb begin
    state_n  = state_q;
    rem_n    = rem_q;
    dcnt_n   = dcnt_q;
    idx_n    = idx;
    take     = 1'b0;
    cap      = 1'b0;
    fin      = 1'b0;
    zero_job = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            rem_n   = k_len;
            state_n = S_CLR;
          end else begin
            zero_job = 1'b1;
          end
        end
      end
      S_CLR: state_n = S_LOAD;
      S_LOAD: begin
        if (in_valid && in_ready) begin
          take    = 1'b1;
          rem_n   = rem_q - KWIDTH'(1);
          idx_n   = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (idx == IDX_LAST) begin
          dcnt_n  = '0;
          state_n = (rem_q != '0) ? S_LOAD : S_DRAIN;
        end else begin
          idx_n = idx + IDEPTH'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DCNT_LAST) begin
          cap     = 1'b1;
          state_n = S_OUT;
        end else begin
          dcnt_n = dcnt_q + DCW'(1);
        end
      end
      S_OUT: begin
        if (res_valid && res_ready) begin
          fin     = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the chosen transition
  always_comb begin
    busy_n      = (state_n != S_IDLE);
    done_n      = zero_job | fin;
    in_ready_n  = (state_n == S_LOAD);
    clr_n       = (state_n == S_CLR);
    en_i_n      = take;
    en_w_n      = take;
    en_o_n      = (state_n == S_RUN);
    mac_done_n  = (state_n == S_RUN) && (idx_n == IDX_LAST) && (rem_n == '0);
    ifm_n       = take ? in_ifm : ifm;
    wght_n      = take ? in_wght : wght;
    res_valid_n = (state_n == S_OUT);
    res_data_n  = cap ? ofm_d : res_data;
  end

endmodule
